brlshft_seq: RTL and testbench

//  Multi-pass shift sequencer that sits directly upstream of the 4-bit brlshft barrel shifter.
//  - Accepts one shift command at a time over a valid/ready handshake.
//  - Drives brlshft once per cycle, shifting by at most 3 per pass, and feeds each pass output back as the next input.
//  - Returns the final 4-bit result over a valid/ready handshake, so amounts of 0..2^AMT_W-1 are supported.

---
 rtl/brlshft_seq.sv | 142 ++++++++++++++
 tb/tb_brlshft_seq.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/brlshft_seq.sv
// -----------------------------------------------------------------------------
// brlshft_seq
//
// Multi-pass shift sequencer placed directly in front of a 4-bit barrel
// shifter (brlshft). It accepts one shift command at a time and drives the
// shifter for as many cycles as needed. Each pass shifts by at most 3, and
// each pass output is fed back as the next pass input. When the command is
// finished, the 4-bit result is offered on a valid/ready handshake.
//
// Parameters
//   AMT_W        width of cmd_amt (>= 2); largest requested shift is 2^AMT_W-1
//   SAT_LOGICAL  1: a logical shift by >= 4 completes immediately with 0000
//                0: such a shift is iterated pass by pass like any other
//
// Ports
//   clk, rst_n            rising-edge clock, asynchronous active-low reset
//   cmd_valid/cmd_ready   command handshake (ready only while idle)
//   cmd_l_r               1 = left, 0 = right
//   cmd_rot               1 = rotate, 0 = logical shift with zero fill
//   cmd_amt               total shift amount
//   cmd_data              4-bit operand
//   bs_l_r, bs_rot        direction / mode to the barrel shifter
//   bs_sv1, bs_sv0        per-pass shift amount to the barrel shifter
//   bs_in                 barrel shifter operand (always the accumulator)
//   bs_out                barrel shifter result (combinational return path)
//   res_valid/res_ready   result handshake
//   res_data              result (the accumulator)
//   busy                  a command is in flight or its result is pending
// -----------------------------------------------------------------------------
module brlshft_seq #(
    parameter int AMT_W       = 4,
    parameter bit SAT_LOGICAL = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic             cmd_l_r,
    input  logic             cmd_rot,
    input  logic [AMT_W-1:0] cmd_amt,
    input  logic [3:0]       cmd_data,
    output logic             bs_l_r,
    output logic             bs_rot,
    output logic             bs_sv0,
    output logic             bs_sv1,
    output logic [3:0]       bs_in,
    input  logic [3:0]       bs_out,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [3:0]       res_data,
    output logic             busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state, state_nxt;
    logic [3:0]       acc, acc_nxt;
    logic [AMT_W-1:0] rem, rem_nxt;
    logic             dir, dir_nxt;
    logic             rot, rot_nxt;
    logic [1:0]       step;
    logic             amt_big;

    // A logical shift by 4 or more clears every bit, so it can be resolved
    // without touching the shifter when saturation is enabled.
    assign amt_big = ({1'b0, cmd_amt} >= (AMT_W+1)'(4));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            acc   <= 4'd0;
            rem   <= '0;
            dir   <= 1'b0;
            rot   <= 1'b0;
        end else begin
            state <= state_nxt;
            acc   <= acc_nxt;
            rem   <= rem_nxt;
            dir   <= dir_nxt;
            rot   <= rot_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        acc_nxt   = acc;
        rem_nxt   = rem;
        dir_nxt   = dir;
        rot_nxt   = rot;
        step      = 2'd0;
        case (state)
            IDLE: begin
                if (cmd_valid) begin
                    acc_nxt = cmd_data;
                    dir_nxt = cmd_l_r;
                    rot_nxt = cmd_rot;
                    if (cmd_rot) begin
                        // Rotating a 4-bit word by a multiple of 4 is identity.
                        rem_nxt = cmd_amt & AMT_W'(3);
                    end else if (SAT_LOGICAL && amt_big) begin
                        acc_nxt = 4'd0;
                        rem_nxt = '0;
                    end else begin
                        rem_nxt = cmd_amt;
                    end
                    state_nxt = (rem_nxt == '0) ? DONE : RUN;
                end
            end
            RUN: begin
                step      = (rem >= AMT_W'(3)) ? 2'd3 : rem[1:0];
                acc_nxt   = bs_out;
                rem_nxt   = rem - AMT_W'(step);
                state_nxt = (rem_nxt == '0) ? DONE : RUN;
            end
            DONE: begin
                // Result and all state are held until the consumer takes it;
                // new commands are not looked at here.
                if (res_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    assign cmd_ready = (state == IDLE);
    assign res_valid = (state == DONE);
    assign busy      = (state != IDLE);
    assign res_data  = acc;
    assign bs_in     = acc;
    assign bs_l_r    = dir;
    assign bs_rot    = rot;
    assign bs_sv0    = step[0];
    assign bs_sv1    = step[1];

endmodule

// File: tb/tb_brlshft_seq.sv
// -----------------------------------------------------------------------------
// tb_brlshft_seq
//
// Two sequencer instances share one clock and one reset:
//   u_dut0 iterates logical shifts (SAT_LOGICAL = 0)
//   u_dut1 saturates logical shifts (SAT_LOGICAL = 1)
// Each instance has its own behavioural 4-bit barrel shifter.
//
// Every transaction is compared against a reference. The reference computes
// the final result, the pass count and the per-pass values directly from the
// requested total shift amount.
// -----------------------------------------------------------------------------
module tb_brlshft_seq;

    localparam int AMT_W = 4;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             cmd_valid [2];
    logic             cmd_ready [2];
    logic             cmd_l_r   [2];
    logic             cmd_rot   [2];
    logic [AMT_W-1:0] cmd_amt   [2];
    logic [3:0]       cmd_data  [2];
    logic             bs_l_r    [2];
    logic             bs_rot    [2];
    logic             bs_sv0    [2];
    logic             bs_sv1    [2];
    logic [3:0]       bs_in     [2];
    logic [3:0]       bs_out    [2];
    logic             res_valid [2];
    logic             res_ready [2];
    logic [3:0]       res_data  [2];
    logic             busy      [2];

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    brlshft_seq #(.AMT_W(AMT_W), .SAT_LOGICAL(1'b0)) u_dut0 (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid[0]), .cmd_ready(cmd_ready[0]),
        .cmd_l_r(cmd_l_r[0]), .cmd_rot(cmd_rot[0]),
        .cmd_amt(cmd_amt[0]), .cmd_data(cmd_data[0]),
        .bs_l_r(bs_l_r[0]), .bs_rot(bs_rot[0]),
        .bs_sv0(bs_sv0[0]), .bs_sv1(bs_sv1[0]),
        .bs_in(bs_in[0]), .bs_out(bs_out[0]),
        .res_valid(res_valid[0]), .res_ready(res_ready[0]),
        .res_data(res_data[0]), .busy(busy[0])
    );

    brlshft_seq #(.AMT_W(AMT_W), .SAT_LOGICAL(1'b1)) u_dut1 (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid[1]), .cmd_ready(cmd_ready[1]),
        .cmd_l_r(cmd_l_r[1]), .cmd_rot(cmd_rot[1]),
        .cmd_amt(cmd_amt[1]), .cmd_data(cmd_data[1]),
        .bs_l_r(bs_l_r[1]), .bs_rot(bs_rot[1]),
        .bs_sv0(bs_sv0[1]), .bs_sv1(bs_sv1[1]),
        .bs_in(bs_in[1]), .bs_out(bs_out[1]),
        .res_valid(res_valid[1]), .res_ready(res_ready[1]),
        .res_data(res_data[1]), .busy(busy[1])
    );

    // Direct shift of a 4-bit word by s positions (any s >= 0).
    function automatic logic [3:0] ref_shift(logic [3:0] d, bit l, bit r, int s);
        int v;
        int k;
        v = int'(d);
        if (r) begin
            k = s % 4;
            if (l) v = (v << k) | (v >> (4 - k));
            else   v = (v >> k) | (v << (4 - k));
        end else begin
            if (s >= 4)  v = 0;
            else if (l)  v = v << s;
            else         v = v >> s;
        end
        return v[3:0];
    endfunction

    // Behavioural barrel shifters answering each sequencer.
    always_comb begin
        for (int i = 0; i < 2; i++) begin
            bs_out[i] = ref_shift(bs_in[i], bs_l_r[i], bs_rot[i], int'({bs_sv1[i], bs_sv0[i]}));
        end
    end

    task automatic check_val(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Issue one command to instance i and follow it through to the result
    // handshake, holding res_ready low for 'stall' extra cycles while
    // cmd_valid is pulsed. Called #1 after a rising edge.
    task automatic run_cmd(input int i, input bit l, input bit r, input int amt,
                           input logic [3:0] d, input int stall, input string tag);
        int loaded;
        int n_pass;
        int rem;
        int shifted;
        int stp;
        logic [3:0] exp_res;
        loaded  = r ? (amt % 4) : ((i == 1 && amt >= 4) ? 0 : amt);
        n_pass  = (loaded + 2) / 3;
        exp_res = ref_shift(d, l, r, amt);
        rem     = loaded;
        shifted = 0;

        check_val({tag, ".ready"}, int'(cmd_ready[i]), 1);
        cmd_valid[i] = 1'b1;
        cmd_l_r[i]   = l;
        cmd_rot[i]   = r;
        cmd_amt[i]   = AMT_W'(amt);
        cmd_data[i]  = d;
        @(posedge clk);
        #1;
        cmd_valid[i] = 1'b0;
        cmd_data[i]  = 4'($urandom);
        cmd_amt[i]   = AMT_W'($urandom);

        for (int c = 0; c <= n_pass; c++) begin
            if (c > 0) begin
                @(posedge clk);
                #1;
            end
            check_val({tag, ".res_valid"}, int'(res_valid[i]), (c == n_pass) ? 1 : 0);
            check_val({tag, ".busy"}, int'(busy[i]), 1);
            check_val({tag, ".l_r"}, int'(bs_l_r[i]), int'(l));
            if (c < n_pass) begin
                stp = (rem > 3) ? 3 : rem;
                check_val({tag, ".sv"}, int'({bs_sv1[i], bs_sv0[i]}), stp);
                check_val({tag, ".bs_in"}, int'(bs_in[i]), int'(ref_shift(d, l, r, shifted)));
                shifted += stp;
                rem     -= stp;
            end else begin
                check_val({tag, ".sv_done"}, int'({bs_sv1[i], bs_sv0[i]}), 0);
                check_val({tag, ".res_data"}, int'(res_data[i]), int'(exp_res));
            end
        end

        for (int s = 0; s < stall; s++) begin
            cmd_valid[i] = (s % 2 == 0);
            cmd_data[i]  = 4'($urandom);
            @(posedge clk);
            #1;
            check_val({tag, ".hold_valid"}, int'(res_valid[i]), 1);
            check_val({tag, ".hold_data"}, int'(res_data[i]), int'(exp_res));
            check_val({tag, ".hold_ready"}, int'(cmd_ready[i]), 0);
        end
        cmd_valid[i] = 1'b0;

        res_ready[i] = 1'b1;
        @(posedge clk);
        #1;
        res_ready[i] = 1'b0;
        check_val({tag, ".post_valid"}, int'(res_valid[i]), 0);
        check_val({tag, ".post_ready"}, int'(cmd_ready[i]), 1);
        check_val({tag, ".post_busy"}, int'(busy[i]), 0);
    endtask

    initial begin
        rst_n = 1'b0;
        for (int i = 0; i < 2; i++) begin
            cmd_valid[i] = 1'b0;
            cmd_l_r[i]   = 1'b0;
            cmd_rot[i]   = 1'b0;
            cmd_amt[i]   = '0;
            cmd_data[i]  = 4'd0;
            res_ready[i] = 1'b0;
        end
        #12;
        for (int i = 0; i < 2; i++) begin
            check_val("rst.ready", int'(cmd_ready[i]), 1);
            check_val("rst.valid", int'(res_valid[i]), 0);
            check_val("rst.busy", int'(busy[i]), 0);
            check_val("rst.bs_in", int'(bs_in[i]), 0);
            check_val("rst.sv", int'({bs_sv1[i], bs_sv0[i]}), 0);
            check_val("rst.ctl", int'({bs_l_r[i], bs_rot[i]}), 0);
        end
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        run_cmd(0, 1'b1, 1'b0, 5, 4'b1101, 0, "t1");
        run_cmd(0, 1'b0, 1'b1, 7, 4'b1101, 0, "t2");
        run_cmd(0, 1'b1, 1'b0, 0, 4'b1010, 1, "t3a");
        run_cmd(1, 1'b0, 1'b1, 0, 4'b1010, 0, "t3b");
        run_cmd(1, 1'b0, 1'b0, 6, 4'b1111, 0, "t4a");
        run_cmd(1, 1'b1, 1'b0, 2, 4'b0111, 0, "t4b");
        run_cmd(0, 1'b1, 1'b0, 15, 4'b1001, 0, "t4c");
        run_cmd(0, 1'b0, 1'b1, 6, 4'b0110, 5, "t5");
        run_cmd(0, 1'b1, 1'b0, 3, 4'b0011, 0, "t5n");

        // Reset during the first pass of a multi-pass command.
        check_val("t6.ready", int'(cmd_ready[0]), 1);
        cmd_valid[0] = 1'b1;
        cmd_l_r[0]   = 1'b1;
        cmd_rot[0]   = 1'b0;
        cmd_amt[0]   = AMT_W'(5);
        cmd_data[0]  = 4'b1101;
        @(posedge clk);
        #1;
        cmd_valid[0] = 1'b0;
        check_val("t6.run_busy", int'(busy[0]), 1);
        #1;
        rst_n = 1'b0;
        #1;
        check_val("t6.ready", int'(cmd_ready[0]), 1);
        check_val("t6.valid", int'(res_valid[0]), 0);
        check_val("t6.busy", int'(busy[0]), 0);
        check_val("t6.acc", int'(bs_in[0]), 0);
        check_val("t6.sv", int'({bs_sv1[0], bs_sv0[0]}), 0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(posedge clk);
            #1;
            check_val("t6.no_result", int'(res_valid[0]), 0);
            check_val("t6.idle", int'(busy[0]), 0);
        end

        for (int k = 0; k < 60; k++) begin
            run_cmd(k % 2, 1'($urandom), 1'($urandom), int'($urandom_range(0, 15)),
                    4'($urandom), int'($urandom_range(0, 2)), "rnd");
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
